// File: rtl/mem_stage_pkg.sv
// -----------------------------------------------------------------------------
// mem_stage_pkg
// Shared encodings for the core_lapido memory-access stage:
//   - write-back source select (WB_SRC_*)
//   - data-memory interface FSM states (MEM_ST_*)
//   - default widths used by the stage
// -----------------------------------------------------------------------------
package mem_stage_pkg;

  localparam int GPR_WIDTH_DEF       = 32;
  localparam int PC_WIDTH_DEF        = 32;
  localparam int DMEM_ADDR_WIDTH_DEF = 32;
  localparam int REG_ADDR_WIDTH_DEF  = 4;

  // Write-back source select carried in the EX/MEM register
  localparam logic [1:0] WB_SRC_ALU = 2'b00;
  localparam logic [1:0] WB_SRC_MEM = 2'b01;
  localparam logic [1:0] WB_SRC_PC  = 2'b10;
  localparam logic [1:0] WB_SRC_IMM = 2'b11;

  typedef enum logic [1:0] {
    MEM_ST_IDLE = 2'd0,
    MEM_ST_REQ  = 2'd1,
    MEM_ST_DONE = 2'd2
  } mem_st_e;

  // A memory operation is a store, or a register write sourced from memory.
  function automatic logic is_mem_op(input logic       mem_write_enable,
                                     input logic       reg_write_enable,
                                     input logic [1:0] wb_res_mux);
    return mem_write_enable | (reg_write_enable & (wb_res_mux == WB_SRC_MEM));
  endfunction

endpackage

// File: rtl/mem_stage_dmem_if_fsm.sv
// -----------------------------------------------------------------------------
// dmem_if_fsm
// Data-memory req/ack sequencer for the MEM stage.
//   clk, rst      : clock, synchronous active-high reset
//   mem_op        : current EX/MEM instruction needs a memory access
//   is_store      : access is a write (store wins over load)
//   addr_in       : access address from EX/MEM
//   wdata_in      : store data from EX/MEM
//   dmem_req/we/addr/wdata : registered request to data memory
//   dmem_rdata/ack: response from data memory
//   stall         : hold the front of the pipeline (combinational)
//   rdata         : read data captured on the acknowledged cycle
// Sequence: IDLE -> REQ (held until ack) -> DONE -> IDLE. Upstream advances in
// the DONE cycle, so a following access always sees one IDLE cycle first.
// -----------------------------------------------------------------------------
module dmem_if_fsm
  import mem_stage_pkg::*;
#(
  parameter int GPR_WIDTH       = GPR_WIDTH_DEF,
  parameter int DMEM_ADDR_WIDTH = DMEM_ADDR_WIDTH_DEF
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       mem_op,
  input  logic                       is_store,
  input  logic [GPR_WIDTH-1:0]       addr_in,
  input  logic [GPR_WIDTH-1:0]       wdata_in,
  output logic                       dmem_req,
  output logic                       dmem_we,
  output logic [DMEM_ADDR_WIDTH-1:0] dmem_addr,
  output logic [GPR_WIDTH-1:0]       dmem_wdata,
  input  logic [GPR_WIDTH-1:0]       dmem_rdata,
  input  logic                       dmem_ack,
  output logic                       stall,
  output logic [GPR_WIDTH-1:0]       rdata
);

  mem_st_e                    state_q, state_d;
  logic                       req_d, we_d;
  logic [DMEM_ADDR_WIDTH-1:0] addr_d;
  logic [GPR_WIDTH-1:0]       wdata_d, rdata_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= MEM_ST_IDLE;
      dmem_req   <= 1'b0;
      dmem_we    <= 1'b0;
      dmem_addr  <= '0;
      dmem_wdata <= '0;
      rdata      <= '0;
    end else begin
      state_q    <= state_d;
      dmem_req   <= req_d;
      dmem_we    <= we_d;
      dmem_addr  <= addr_d;
      dmem_wdata <= wdata_d;
      rdata      <= rdata_d;
    end
  end

  always_comb begin
    state_d = state_q;
    req_d   = dmem_req;
    we_d    = dmem_we;
    addr_d  = dmem_addr;
    wdata_d = dmem_wdata;
    rdata_d = rdata;
    unique case (state_q)
      MEM_ST_IDLE: begin
        if (mem_op) begin
          state_d = MEM_ST_REQ;
          req_d   = 1'b1;
          we_d    = is_store;
          addr_d  = DMEM_ADDR_WIDTH'(addr_in);
          wdata_d = wdata_in;
        end
      end
      MEM_ST_REQ: begin
        // Request fields stay frozen until the memory acknowledges.
        if (dmem_ack) begin
          state_d = MEM_ST_DONE;
          req_d   = 1'b0;
          rdata_d = dmem_rdata;
        end
      end
      MEM_ST_DONE: begin
        state_d = MEM_ST_IDLE;
      end
      default: begin
        state_d = MEM_ST_IDLE;
        req_d   = 1'b0;
      end
    endcase
  end

  // The DONE cycle is the one in which the stalled instruction moves on.
  assign stall = mem_op & (state_q != MEM_ST_DONE);

endmodule

// File: rtl/mem_stage.sv
// -----------------------------------------------------------------------------
// mem_stage
// Memory-access stage of the core_lapido 5-stage pipeline.
// Inputs  : EX/MEM register fields (in_*), data-memory response (dmem_rdata,
//           dmem_ack), clk / rst (synchronous, active-high).
// Outputs : data-memory request (dmem_req/we/addr/wdata), pipeline stall,
//           branch decision pass-through to IF (branch_taken/branch_addr),
//           EX forwarding value (ex_mem_fwd_data), MEM/WB register
//           (out_reg_write_enable/out_reg_dest/out_wb_data) and a cumulative
//           stall-cycle counter (out_stall_count).
// -----------------------------------------------------------------------------
module mem_stage
  import mem_stage_pkg::*;
#(
  parameter int GPR_WIDTH       = GPR_WIDTH_DEF,
  parameter int PC_WIDTH        = PC_WIDTH_DEF,
  parameter int DMEM_ADDR_WIDTH = DMEM_ADDR_WIDTH_DEF,
  parameter int REG_ADDR_WIDTH  = REG_ADDR_WIDTH_DEF
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       in_mem_write_enable,
  input  logic [1:0]                 in_wb_res_mux,
  input  logic                       in_reg_write_enable,
  input  logic [REG_ADDR_WIDTH-1:0]  in_reg_dest,
  input  logic [GPR_WIDTH-1:0]       in_alu_res,
  input  logic [GPR_WIDTH-1:0]       in_imm,
  input  logic [PC_WIDTH-1:0]        in_next_pc,
  input  logic [GPR_WIDTH-1:0]       in_mem_addr,
  input  logic [GPR_WIDTH-1:0]       in_mem_data,
  input  logic                       in_branch_taken,
  input  logic [PC_WIDTH-1:0]        in_branch_addr,
  output logic                       dmem_req,
  output logic                       dmem_we,
  output logic [DMEM_ADDR_WIDTH-1:0] dmem_addr,
  output logic [GPR_WIDTH-1:0]       dmem_wdata,
  input  logic [GPR_WIDTH-1:0]       dmem_rdata,
  input  logic                       dmem_ack,
  output logic                       stall,
  output logic                       branch_taken,
  output logic [PC_WIDTH-1:0]        branch_addr,
  output logic [GPR_WIDTH-1:0]       ex_mem_fwd_data,
  output logic                       out_reg_write_enable,
  output logic [REG_ADDR_WIDTH-1:0]  out_reg_dest,
  output logic [GPR_WIDTH-1:0]       out_wb_data,
  output logic [31:0]                out_stall_count
);

  logic                 mem_op;
  logic [GPR_WIDTH-1:0] mem_rdata;
  logic [GPR_WIDTH-1:0] wb_data_p0;

  assign mem_op = is_mem_op(in_mem_write_enable, in_reg_write_enable, in_wb_res_mux);

  dmem_if_fsm #(
    .GPR_WIDTH       (GPR_WIDTH),
    .DMEM_ADDR_WIDTH (DMEM_ADDR_WIDTH)
  ) u_dmem_if_fsm (
    .clk        (clk),
    .rst        (rst),
    .mem_op     (mem_op),
    .is_store   (in_mem_write_enable),
    .addr_in    (in_mem_addr),
    .wdata_in   (in_mem_data),
    .dmem_req   (dmem_req),
    .dmem_we    (dmem_we),
    .dmem_addr  (dmem_addr),
    .dmem_wdata (dmem_wdata),
    .dmem_rdata (dmem_rdata),
    .dmem_ack   (dmem_ack),
    .stall      (stall),
    .rdata      (mem_rdata)
  );

  // Branch resolution is already complete; IF only needs it forwarded.
  assign branch_taken = in_branch_taken;
  assign branch_addr  = in_branch_addr;

  // Loads are never forwarded from here: the hazard unit stalls EX instead.
  always_comb begin
    unique case (in_wb_res_mux)
      WB_SRC_PC:  ex_mem_fwd_data = GPR_WIDTH'(in_next_pc);
      WB_SRC_IMM: ex_mem_fwd_data = in_imm;
      default:    ex_mem_fwd_data = in_alu_res;
    endcase
  end

  always_comb begin
    unique case (in_wb_res_mux)
      WB_SRC_ALU: wb_data_p0 = in_alu_res;
      WB_SRC_MEM: wb_data_p0 = mem_rdata;
      WB_SRC_PC:  wb_data_p0 = GPR_WIDTH'(in_next_pc);
      default:    wb_data_p0 = in_imm;
    endcase
  end

  // ---- MEM/WB register boundary ----
  // A stalled cycle inserts a bubble: only the write enable is cleared, the
  // remaining fields keep their last value.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_reg_write_enable <= 1'b0;
      out_reg_dest         <= '0;
      out_wb_data          <= '0;
      out_stall_count      <= '0;
    end else begin
      if (stall) begin
        out_reg_write_enable <= 1'b0;
        out_stall_count      <= out_stall_count + 32'd1;
      end else begin
        out_reg_write_enable <= in_reg_write_enable;
        out_reg_dest         <= in_reg_dest;
        out_wb_data          <= wb_data_p0;
      end
    end
  end

endmodule

// File: tb/tb_mem_stage.sv
module tb_mem_stage;
  import mem_stage_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_mem_write_enable;
  logic [1:0]  in_wb_res_mux;
  logic        in_reg_write_enable;
  logic [3:0]  in_reg_dest;
  logic [31:0] in_alu_res, in_imm, in_next_pc, in_mem_addr, in_mem_data;
  logic        in_branch_taken;
  logic [31:0] in_branch_addr;
  logic        dmem_req, dmem_we;
  logic [31:0] dmem_addr, dmem_wdata, dmem_rdata;
  logic        dmem_ack;
  logic        stall, branch_taken;
  logic [31:0] branch_addr, ex_mem_fwd_data;
  logic        out_reg_write_enable;
  logic [3:0]  out_reg_dest;
  logic [31:0] out_wb_data, out_stall_count;

  always #5 clk = ~clk;

  mem_stage dut (
    .clk                  (clk),
    .rst                  (rst),
    .in_mem_write_enable  (in_mem_write_enable),
    .in_wb_res_mux        (in_wb_res_mux),
    .in_reg_write_enable  (in_reg_write_enable),
    .in_reg_dest          (in_reg_dest),
    .in_alu_res           (in_alu_res),
    .in_imm               (in_imm),
    .in_next_pc           (in_next_pc),
    .in_mem_addr          (in_mem_addr),
    .in_mem_data          (in_mem_data),
    .in_branch_taken      (in_branch_taken),
    .in_branch_addr       (in_branch_addr),
    .dmem_req             (dmem_req),
    .dmem_we              (dmem_we),
    .dmem_addr            (dmem_addr),
    .dmem_wdata           (dmem_wdata),
    .dmem_rdata           (dmem_rdata),
    .dmem_ack             (dmem_ack),
    .stall                (stall),
    .branch_taken         (branch_taken),
    .branch_addr          (branch_addr),
    .ex_mem_fwd_data      (ex_mem_fwd_data),
    .out_reg_write_enable (out_reg_write_enable),
    .out_reg_dest         (out_reg_dest),
    .out_wb_data          (out_wb_data),
    .out_stall_count      (out_stall_count)
  );

  typedef struct packed {
    logic [3:0]  dest;
    logic [31:0] data;
  } wb_t;

  wb_t exp_q[$];
  wb_t mon_e;
  int  n_cmp = 0;
  int  n_bad = 0;
  int  exp_stall_total = 0;

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic set_nop();
    in_mem_write_enable = 1'b0;
    in_wb_res_mux       = WB_SRC_ALU;
    in_reg_write_enable = 1'b0;
    in_reg_dest         = 4'd0;
    in_alu_res          = 32'd0;
    in_imm              = 32'd0;
    in_next_pc          = 32'd0;
    in_mem_addr         = 32'd0;
    in_mem_data         = 32'd0;
    in_branch_taken     = 1'b0;
    in_branch_addr      = 32'd0;
  endtask

  // Monitor: every MEM/WB write is matched against the scoreboard queue.
  initial begin
    forever begin
      @(negedge clk);
      if (rst === 1'b0 && out_reg_write_enable === 1'b1) begin
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL unexpected_wb: got dest %0d data 0x%08h, expected no write",
                   out_reg_dest, out_wb_data);
        end else begin
          mon_e = exp_q.pop_front();
          check32("wb_dest", 32'(out_reg_dest), 32'(mon_e.dest));
          check32("wb_data", out_wb_data, mon_e.data);
        end
      end
    end
  end

  // Issue one EX/MEM instruction (called at a negedge), act as data memory,
  // and return at the negedge after the instruction leaves the stage.
  task automatic run_op(input string tag, input logic we, input logic [1:0] mux,
                        input logic rwe, input logic [3:0] dest,
                        input logic [31:0] alu, input logic [31:0] imm,
                        input logic [31:0] npc, input logic [31:0] addr,
                        input logic [31:0] wdata, input logic [31:0] rdata,
                        input logic br, input logic [31:0] br_addr,
                        input int ack_delay, input int exp_stall,
                        input logic [31:0] exp_wb, input logic [31:0] exp_fwd);
    int  stalls = 0;
    int  reqs   = 0;
    bit  done   = 0;
    wb_t e;
    in_mem_write_enable = we;
    in_wb_res_mux       = mux;
    in_reg_write_enable = rwe;
    in_reg_dest         = dest;
    in_alu_res          = alu;
    in_imm              = imm;
    in_next_pc          = npc;
    in_mem_addr         = addr;
    in_mem_data         = wdata;
    in_branch_taken     = br;
    in_branch_addr      = br_addr;
    for (int cyc = 0; cyc < 40 && !done; cyc++) begin
      #1;
      if (cyc == 0) begin
        check32({tag, "_fwd"}, ex_mem_fwd_data, exp_fwd);
        check32({tag, "_br_taken"}, 32'(branch_taken), 32'(br));
        check32({tag, "_br_addr"}, branch_addr, br_addr);
      end
      if (stall) begin
        stalls++;
        if (dmem_req) begin
          reqs++;
          check32({tag, "_dmem_we"}, 32'(dmem_we), 32'(we));
          check32({tag, "_dmem_addr"}, dmem_addr, addr);
          check32({tag, "_dmem_wdata"}, dmem_wdata, wdata);
          if (reqs == ack_delay) begin
            dmem_ack   = 1'b1;
            dmem_rdata = rdata;
          end
        end
      end else begin
        done = 1;
        if (exp_stall > 0) check32({tag, "_req_done"}, 32'(dmem_req), 32'd0);
        if (rwe) begin
          e.dest = dest;
          e.data = exp_wb;
          exp_q.push_back(e);
        end
      end
      @(posedge clk);
      #1;
      dmem_ack   = 1'b0;
      dmem_rdata = 32'hBAD0_BAD0;
      if (done) set_nop();
      @(negedge clk);
    end
    if (!done) begin
      n_cmp++;
      n_bad++;
      $display("FAIL %s_timeout: got stall still high, expected completion", tag);
    end
    check32({tag, "_stall_cycles"}, 32'(stalls), 32'(exp_stall));
    exp_stall_total += exp_stall;
    check32({tag, "_stall_count"}, out_stall_count, 32'(exp_stall_total));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no completion, expected $finish");
    $fatal(1);
  end

  initial begin
    rst        = 1'b1;
    dmem_ack   = 1'b0;
    dmem_rdata = 32'hBAD0_BAD0;
    set_nop();
    repeat (2) @(posedge clk);
    #1;
    check32("rst_dmem_req", 32'(dmem_req), 32'd0);
    check32("rst_dmem_addr", dmem_addr, 32'd0);
    check32("rst_wb_we", 32'(out_reg_write_enable), 32'd0);
    check32("rst_wb_data", out_wb_data, 32'd0);
    check32("rst_stall_count", out_stall_count, 32'd0);
    check32("rst_stall", 32'(stall), 32'd0);
    @(negedge clk);
    rst = 1'b0;

    // tag, we, mux, rwe, dest, alu, imm, npc, addr, wdata, rdata, br, br_addr,
    // ack_delay, exp_stall, exp_wb, exp_fwd
    run_op("alu", 1'b0, WB_SRC_ALU, 1'b1, 4'd3, 32'h0000_00AA, 32'h1, 32'h2,
           32'h0, 32'h0, 32'h0, 1'b0, 32'h0, 0, 0, 32'h0000_00AA, 32'h0000_00AA);
    run_op("store", 1'b1, WB_SRC_ALU, 1'b0, 4'd0, 32'h0000_0010, 32'h0, 32'h0,
           32'h0000_0010, 32'hDEAD_BEEF, 32'h0, 1'b0, 32'h0, 3, 4, 32'h0, 32'h0000_0010);
    run_op("load", 1'b0, WB_SRC_MEM, 1'b1, 4'd5, 32'h0000_0020, 32'h0, 32'h0,
           32'h0000_0020, 32'h0, 32'h1234_5678, 1'b0, 32'h0, 1, 2, 32'h1234_5678,
           32'h0000_0020);
    run_op("jal", 1'b0, WB_SRC_PC, 1'b1, 4'hF, 32'h0000_0077, 32'h0, 32'h0000_000C,
           32'h0, 32'h0, 32'h0, 1'b1, 32'h0000_0040, 0, 0, 32'h0000_000C, 32'h0000_000C);
    run_op("imm", 1'b0, WB_SRC_IMM, 1'b1, 4'd7, 32'h0000_0001, 32'h0000_5555, 32'h4,
           32'h0, 32'h0, 32'h0, 1'b0, 32'h0, 0, 0, 32'h0000_5555, 32'h0000_5555);
    run_op("load2", 1'b0, WB_SRC_MEM, 1'b1, 4'd9, 32'h0000_0024, 32'h0, 32'h0,
           32'h0000_0024, 32'h0, 32'hCAFE_F00D, 1'b0, 32'h0, 2, 3, 32'hCAFE_F00D,
           32'h0000_0024);

    // Reset in the middle of an outstanding store.
    in_mem_write_enable = 1'b1;
    in_mem_addr         = 32'h0000_0050;
    in_mem_data         = 32'h5A5A_5A5A;
    @(posedge clk);
    #1;
    check32("midreq_req", 32'(dmem_req), 32'd1);
    @(negedge clk);
    rst = 1'b1;
    set_nop();
    @(posedge clk);
    #1;
    check32("midreq_rst_req", 32'(dmem_req), 32'd0);
    check32("midreq_rst_we", 32'(dmem_we), 32'd0);
    check32("midreq_rst_addr", dmem_addr, 32'd0);
    check32("midreq_rst_wdata", dmem_wdata, 32'd0);
    check32("midreq_rst_stall", 32'(stall), 32'd0);
    check32("midreq_rst_count", out_stall_count, 32'd0);
    check32("midreq_rst_wb_we", 32'(out_reg_write_enable), 32'd0);
    check32("midreq_rst_wb_dest", 32'(out_reg_dest), 32'd0);
    check32("midreq_rst_wb_data", out_wb_data, 32'd0);
    exp_stall_total = 0;
    @(negedge clk);
    rst        = 1'b0;
    dmem_ack   = 1'b1;
    dmem_rdata = 32'h1111_1111;
    @(posedge clk);
    #1;
    dmem_ack   = 1'b0;
    dmem_rdata = 32'hBAD0_BAD0;
    check32("stray_ack_req", 32'(dmem_req), 32'd0);
    @(negedge clk);
    check32("stray_ack_wb_we", 32'(out_reg_write_enable), 32'd0);
    check32("stray_ack_count", out_stall_count, 32'd0);

    run_op("load3", 1'b0, WB_SRC_MEM, 1'b1, 4'd2, 32'h0000_0030, 32'h0, 32'h0,
           32'h0000_0030, 32'h0, 32'hA5A5_0F0F, 1'b0, 32'h0, 1, 2, 32'hA5A5_0F0F,
           32'h0000_0030);

    repeat (3) @(negedge clk);
    check32("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/mem_stage.md
Name: mem_stage

Overview:
- Memory-access stage of the core_lapido 5-stage pipeline.
- Consumes the EX/MEM pipeline register and performs data-memory loads/stores over a req/ack handshake.
- Stalls the front of the pipeline until the access completes, then loads the MEM/WB register with the resolved write-back data.
- Returns the branch decision/target to IF and the EX-stage forwarding value (EX_MEM_data).

Parameters:
GPR_WIDTH, 32, data/register width
PC_WIDTH, 32, program counter width
DMEM_ADDR_WIDTH, 32, data memory address width
REG_ADDR_WIDTH, 4, register-file address width (R15 = 4'hF)

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
in_mem_write_enable  in  1  store request from EX/MEM
in_wb_res_mux  in  2  write-back source select
in_reg_write_enable  in  1  register write enable
in_reg_dest  in  REG_ADDR_WIDTH  destination register
in_alu_res  in  GPR_WIDTH  ALU result
in_imm  in  GPR_WIDTH  immediate
in_next_pc  in  PC_WIDTH  pc+1
in_mem_addr  in  GPR_WIDTH  data address
in_mem_data  in  GPR_WIDTH  store data
in_branch_taken  in  1  branch resolved taken
in_branch_addr  in  PC_WIDTH  branch target
dmem_req  out  1  memory request (registered)
dmem_we  out  1  1 = write, 0 = read
dmem_addr  out  DMEM_ADDR_WIDTH  memory address
dmem_wdata  out  GPR_WIDTH  write data
dmem_rdata  in  GPR_WIDTH  read data, valid with ack
dmem_ack  in  1  access complete
stall  out  1  freeze PC, IF/ID, ID/EX and EX/MEM
branch_taken  out  1  flush request to IF/ID/EX (= in_branch_taken)
branch_addr  out  PC_WIDTH  PC target (= in_branch_addr)
ex_mem_fwd_data  out  GPR_WIDTH  forwarding value to EX
out_reg_write_enable  out  1  MEM/WB write enable
out_reg_dest  out  REG_ADDR_WIDTH  MEM/WB destination
out_wb_data  out  GPR_WIDTH  MEM/WB write-back value
out_stall_count  out  32  cumulative stall cycles

Behaviour:
- Write-back source encoding: WB_SRC_ALU = 00, WB_SRC_MEM = 01, WB_SRC_PC = 10, WB_SRC_IMM = 11.
- mem_op = in_mem_write_enable | (in_reg_write_enable & in_wb_res_mux == WB_SRC_MEM).
- Load = mem_op with in_mem_write_enable = 0. If both a load and a store are indicated, the store wins.
- FSM states:
  - IDLE: if mem_op, go to REQ. Registered dmem_req = 1 and dmem_we/addr/wdata are latched from the inputs.
  - REQ: hold dmem_req and the latched fields stable until dmem_ack. On ack, latch dmem_rdata and go to DONE.
  - DONE: next cycle return to IDLE, dmem_req = 0. Not expected to see mem_op again: upstream advanced on the DONE cycle.
- A new mem_op seen in IDLE re-enters REQ; back-to-back accesses are separated by one IDLE cycle.
- stall = mem_op & (state != DONE), combinational. Minimum memory-op cost is 2 stall cycles (ack in the first REQ cycle).
- dmem_ack outside REQ is ignored. dmem_rdata is sampled only in the REQ & ack cycle.
- MEM/WB register (registered, updates every cycle):
  - While stall = 1: bubble, out_reg_write_enable = 0, other MEM/WB fields hold.
  - Otherwise: out_reg_write_enable = in_reg_write_enable and out_reg_dest = in_reg_dest.
  - out_wb_data by source: ALU → in_alu_res, MEM → latched rdata, PC → zero-extended in_next_pc, IMM → in_imm.
- ex_mem_fwd_data, combinational: source PC → in_next_pc, IMM → in_imm, else in_alu_res. Load results are not forwarded from this stage; the hazard unit stalls instead.
- branch_taken/branch_addr are pure pass-throughs. The branch instruction still writes back (e.g. pc+1 to R15).
- out_stall_count increments each cycle stall = 1 and wraps at 2^32.
- Reset, taking effect on the next clk edge, including mid-access:
  - state = IDLE, dmem_req = 0, dmem_we = 0, dmem_addr = 0, dmem_wdata = 0.
  - out_reg_write_enable = 0, out_reg_dest = 0, out_wb_data = 0, out_stall_count = 0, latched rdata = 0.
  - The memory discards any outstanding request when it sees req drop.

Decomposition:
- lapido_defs.v gains WB_SRC_ALU/MEM/PC/IMM and MEM_ST_IDLE/REQ/DONE. Widths come from the existing GPR_WIDTH/PC_WIDTH/DATA_MEM_ADDR_WIDTH defines.
- One natural sub-module: dmem_if_fsm, holding the FSM, the dmem_* registers and the rdata latch, and exporting stall plus rdata.

Test Plan:
- ALU pass-through: in_wb_res_mux = 00, in_reg_write_enable = 1, in_alu_res = 0x0000_00AA, in_reg_dest = 3 → next cycle out_wb_data = 0xAA, out_reg_dest = 3, write enable 1, stall never asserted.
- Store, ack 3 cycles after req: in_mem_write_enable = 1, addr = 0x10, data = 0xDEAD_BEEF → dmem_req/dmem_we = 1 with addr/wdata stable all 3 cycles; stall high 4 cycles; out_reg_write_enable stays 0; out_stall_count = 4.
- Load, immediate ack: wb_res_mux = 01, addr = 0x20, rdata = 0x1234_5678 → stall for 2 cycles, then out_wb_data = 0x1234_5678 with write enable 1 exactly once.
- Jump-and-link branch: in_branch_taken = 1, in_branch_addr = 0x40, wb_res_mux = 10, in_next_pc = 0x0C, dest = 4'hF → branch_taken = 1 and branch_addr = 0x40 the same cycle; next cycle out_wb_data = 0x0C into R15.
- Reset mid-REQ: assert rst while dmem_req = 1 before ack → next edge dmem_req = 0, stall = 0 with mem_op deasserted, all outputs and counter zero; a stray dmem_ack afterwards causes no write.
